// File: rtl/gestos_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gestos_pkg
// Brief   : Shared types and finger-to-gesture code map for controlador_gestos.
// Revision: 1.0 - initial release
// ============================================================================
package gestos_pkg;

  typedef enum logic [1:0] {
    NINGUNO = 2'b00,
    G1      = 2'b01,
    G2      = 2'b10,
    G3      = 2'b11
  } gesto_t;

  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    FILTRO = 2'd1,
    VALIDO = 2'd2,
    SOLTAR = 2'd3
  } estado_t;

  // Only contiguous runs starting at finger A form a gesture
  function automatic gesto_t mapa_dedos(input logic [3:0] dedos);
    case (dedos)
      4'b0011: mapa_dedos = G1;
      4'b0111: mapa_dedos = G2;
      4'b1111: mapa_dedos = G3;
      default: mapa_dedos = NINGUNO;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/controlador_gestos_sincronizador.sv
`default_nettype none
// ============================================================================
// Module  : sincronizador
// Brief   : Parameterised-width two-flop synchroniser, synchronous reset to 0.
// Revision: 1.0 - initial release
// ============================================================================
module sincronizador #(
  parameter int ANCHO = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ANCHO-1:0] d,
  output logic [ANCHO-1:0] q
);

  logic [ANCHO-1:0] r_meta;
  logic [ANCHO-1:0] r_sinc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sinc <= '0;
    end else begin
      r_meta <= d;
      r_sinc <= r_meta;
    end
  end

  assign q = r_sinc;

endmodule
`default_nettype wire

// File: rtl/controlador_gestos.sv
`default_nettype none
// ============================================================================
// Module  : controlador_gestos
// Brief   : Debounces finger sensors into a gesture code, offers it once over
//           valid/ready and waits for hand release. Optional macro
//           GESTO_TIMEOUT_EN drops an unclaimed gesture after TIMEOUT cycles.
// Revision: 1.0 - initial release
// ============================================================================
module controlador_gestos
  import gestos_pkg::*;
#(
  parameter int ESTABLE = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dedos,
  input  logic       listo,
  output logic       gesto_valido,
  output logic [1:0] gesto,
  output logic       ocupado,
  output logic       error_timeout
);

  localparam int                     c_ANCHO_CNT = $clog2(ESTABLE + 1);
  localparam logic [c_ANCHO_CNT-1:0] c_CNT_UNO   = c_ANCHO_CNT'(1);
  localparam logic [c_ANCHO_CNT-1:0] c_CNT_FIN   = c_ANCHO_CNT'(ESTABLE - 1);

  if (ESTABLE < 2) begin : g_chk_estable
    $error("controlador_gestos: ESTABLE must be >= 2");
  end
  if (TIMEOUT < 2) begin : g_chk_timeout
    $error("controlador_gestos: TIMEOUT must be >= 2");
  end

  logic [3:0]             w_dedos_s;
  gesto_t                 w_codigo;
  estado_t                r_estado,    w_estado_sig;
  gesto_t                 r_candidato, w_candidato_sig;
  gesto_t                 r_gesto,     w_gesto_sig;
  logic [c_ANCHO_CNT-1:0] r_cnt,       w_cnt_sig;
  logic                   r_valido;
  logic                   r_ocupado;
  logic                   w_expira;

  sincronizador #(.ANCHO(4)) u_sinc (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dedos),
    .q     (w_dedos_s)
  );

  assign w_codigo = mapa_dedos(w_dedos_s);

`ifdef GESTO_TIMEOUT_EN
  localparam int                    c_ANCHO_TO = $clog2(TIMEOUT + 1);
  localparam logic [c_ANCHO_TO-1:0] c_TO_FIN   = c_ANCHO_TO'(TIMEOUT - 1);

  logic [c_ANCHO_TO-1:0] r_to_cnt;
  logic                  r_error;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      r_error  <= 1'b0;
    end else begin
      r_to_cnt <= (r_estado == VALIDO) ? r_to_cnt + 1'b1 : '0;
      r_error  <= w_expira;
    end
  end

  // A listo on the expiry edge wins: the handshake completes without error
  assign w_expira      = (r_estado == VALIDO) && (r_to_cnt == c_TO_FIN) && !listo;
  assign error_timeout = r_error;
`else
  assign w_expira      = 1'b0;
  assign error_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado    <= ESPERA;
      r_candidato <= NINGUNO;
      r_gesto     <= NINGUNO;
      r_cnt       <= '0;
      r_valido    <= 1'b0;
      r_ocupado   <= 1'b0;
    end else begin
      r_estado    <= w_estado_sig;
      r_candidato <= w_candidato_sig;
      r_gesto     <= w_gesto_sig;
      r_cnt       <= w_cnt_sig;
      r_valido    <= (w_estado_sig == VALIDO);
      r_ocupado   <= (w_estado_sig != ESPERA);
    end
  end

  always_comb begin
    w_estado_sig    = r_estado;
    w_candidato_sig = r_candidato;
    w_gesto_sig     = r_gesto;
    w_cnt_sig       = r_cnt;
    case (r_estado)
      ESPERA: begin
        if (w_codigo != NINGUNO) begin
          w_estado_sig    = FILTRO;
          w_candidato_sig = w_codigo;
          w_cnt_sig       = c_CNT_UNO;
        end
      end
      FILTRO: begin
        if (w_codigo == NINGUNO) begin
          w_estado_sig = ESPERA;
        end else if (w_codigo != r_candidato) begin
          w_candidato_sig = w_codigo;
          w_cnt_sig       = c_CNT_UNO;
        end else if (r_cnt == c_CNT_FIN) begin
          w_estado_sig = VALIDO;
          w_gesto_sig  = r_candidato;
        end else begin
          w_cnt_sig = r_cnt + 1'b1;
        end
      end
      VALIDO: begin
        if (listo || w_expira) begin
          w_estado_sig = SOLTAR;
          w_cnt_sig    = '0;
        end
      end
      SOLTAR: begin
        // Any finger back on the sensor restarts the release hold time
        if (w_codigo != NINGUNO) begin
          w_cnt_sig = '0;
        end else if (r_cnt == c_CNT_FIN) begin
          w_estado_sig = ESPERA;
        end else begin
          w_cnt_sig = r_cnt + 1'b1;
        end
      end
      default: w_estado_sig = ESPERA;
    endcase
  end

  assign gesto_valido = r_valido;
  assign gesto        = r_gesto;
  assign ocupado      = r_ocupado;

endmodule
`default_nettype wire

// File: tb/tb_controlador_gestos.sv
`default_nettype none
// ============================================================================
// Module  : tb_controlador_gestos
// Brief   : Directed and random stimulus against a window-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_controlador_gestos;

  localparam int ESTABLE = 4;
  localparam int TIMEOUT = 8;
`ifdef GESTO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dedos = 4'b0000;
  logic       listo = 1'b1;
  logic       gesto_valido;
  logic [1:0] gesto;
  logic       ocupado;
  logic       error_timeout;

  controlador_gestos #(.ESTABLE(ESTABLE), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dedos         (dedos),
    .listo         (listo),
    .gesto_valido  (gesto_valido),
    .gesto         (gesto),
    .ocupado       (ocupado),
    .error_timeout (error_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_ok  = 0;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_chk++;
    if (obs === esp) n_ok++;
    else $display("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, esp, $time);
  endtask

  // Reference model: a phase ends when ESTABLE consecutive samples inside it
  // satisfy its predicate (same nonzero code to accept, all-zero to re-arm).
  logic [3:0] m_s1 = '0, m_s2 = '0;
  int fase = 0;       // 0 armed, 1 offering, 2 releasing
  int run_len = 0, run_code = 0, pend_n = 0, ceros = 0;
  bit e_valido = 0, e_ocupado = 0, e_error = 0;
  int e_gesto = 0;

  function automatic int codigo_de(input logic [3:0] d);
    if (d == 4'b0011) return 1;
    if (d == 4'b0111) return 2;
    if (d == 4'b1111) return 3;
    return 0;
  endfunction

  task automatic modelo(input logic rn, input logic [3:0] d, input logic l);
    int cod;
    cod = codigo_de(m_s2);
    if (!rn) begin
      m_s1 = '0; m_s2 = '0;
      fase = 0; run_len = 0; run_code = 0;
      e_valido = 0; e_ocupado = 0; e_error = 0; e_gesto = 0;
    end else begin
      e_error = 0;
      if (fase == 0) begin
        if (cod == 0) begin
          run_len = 0; e_ocupado = 0;
        end else begin
          if (run_len > 0 && cod == run_code) run_len++;
          else begin run_code = cod; run_len = 1; end
          e_ocupado = 1;
          if (run_len == ESTABLE) begin
            fase = 1; e_valido = 1; e_gesto = run_code; pend_n = 0;
          end
        end
      end else if (fase == 1) begin
        pend_n++;
        if (l) begin
          fase = 2; e_valido = 0; ceros = 0;
        end else if (TO_EN && pend_n == TIMEOUT) begin
          fase = 2; e_valido = 0; e_error = 1; ceros = 0;
        end
      end else begin
        ceros = (cod == 0) ? ceros + 1 : 0;
        if (ceros == ESTABLE) begin
          fase = 0; run_len = 0; e_ocupado = 0;
        end
      end
      m_s2 = m_s1; m_s1 = d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelo(rst_n, dedos, listo);
    #1;
    comprobar("valido", gesto_valido, e_valido);
    comprobar("ocupado", ocupado, e_ocupado);
    comprobar("error", error_timeout, e_error);
    if (e_valido) comprobar("gesto", gesto, e_gesto);
  endtask

  task automatic esperar_valido(output int lat);
    lat = 0;
    for (int i = 1; i <= 16 && lat == 0; i++) begin
      tick();
      if (gesto_valido) lat = i;
    end
  endtask

  task automatic esperar_libre(output int n);
    dedos = 4'b0000; listo = 1'b1; n = 0;
    for (int i = 1; i <= 30 && n == 0; i++) begin
      tick();
      if (!ocupado) n = i;
    end
  endtask

  int lat, n, cuenta, cuenta2;
  logic [1:0] g0;

  initial begin
    // Reset with all fingers down
    rst_n = 1'b0; dedos = 4'b1111; listo = 1'b1;
    tick(); tick();
    comprobar("rst_valido", gesto_valido, 0);
    comprobar("rst_gesto", gesto, 0);
    comprobar("rst_ocupado", ocupado, 0);
    comprobar("rst_error", error_timeout, 0);

    // Basic handshake, gesture held afterwards
    rst_n = 1'b1; dedos = 4'b0011;
    esperar_valido(lat);
    comprobar("lat_basico", lat, 6);
    comprobar("gesto_basico", gesto, 2'b01);
    tick();
    comprobar("valido_un_ciclo", gesto_valido, 0);
    cuenta = 0;
    repeat (20) begin tick(); cuenta += int'(gesto_valido); end
    comprobar("sin_redisparo", cuenta, 0);

    // Glitch of 0111 then 1111
    esperar_libre(n);
    comprobar("rearme", n, 6);
    dedos = 4'b0111; cuenta = 0; lat = 0; g0 = 2'b00;
    repeat (3) begin tick(); if (gesto_valido && gesto == 2'b10) cuenta++; end
    dedos = 4'b1111;
    for (int i = 1; i <= 16 && lat == 0; i++) begin
      tick();
      if (gesto_valido) begin
        if (gesto == 2'b10) cuenta++;
        else begin lat = i; g0 = gesto; end
      end
    end
    comprobar("sin_g2", cuenta, 0);
    comprobar("lat_g3", lat, 6);
    comprobar("gesto_g3", g0, 2'b11);

    // Backpressure: five VALIDO cycles with listo low, inputs changing
    esperar_libre(n);
    dedos = 4'b0011; listo = 1'b0;
    esperar_valido(lat);
    comprobar("bp_lat", lat, 6);
    g0 = gesto; cuenta = 0;
    dedos = 4'b1111;
    repeat (4) begin tick(); if (!gesto_valido || gesto != g0) cuenta++; end
    comprobar("bp_estable", cuenta, 0);
    listo = 1'b1;
    tick();
    comprobar("bp_fin", gesto_valido, 0);
    esperar_libre(n);
    comprobar("bp_soltar", n, 6);

    // Reset while a gesture is being offered
    dedos = 4'b0111; listo = 1'b0;
    esperar_valido(lat);
    comprobar("pre_rst_valido", gesto_valido, 1);
    rst_n = 1'b0;
    tick();
    comprobar("rst_medio_valido", gesto_valido, 0);
    comprobar("rst_medio_ocupado", ocupado, 0);
    rst_n = 1'b1; dedos = 4'b0000; listo = 1'b1;
    repeat (4) tick();

`ifdef GESTO_TIMEOUT_EN
    dedos = 4'b1111; listo = 1'b0;
    esperar_valido(lat);
    n = 0;
    for (int k = 1; k <= 12 && n == 0; k++) begin
      tick();
      if (error_timeout) n = k;
    end
    comprobar("to_ciclos", n, 8);
    comprobar("to_valido_cae", gesto_valido, 0);
    cuenta = 0;
    repeat (10) begin tick(); cuenta += int'(error_timeout); end
    comprobar("to_un_pulso", cuenta, 0);
    esperar_libre(n);
    dedos = 4'b0011; listo = 1'b0;
    esperar_valido(lat);
    cuenta = 0;
    repeat (7) begin tick(); cuenta += int'(error_timeout); end
    listo = 1'b1;
    tick();
    cuenta += int'(error_timeout);
    comprobar("to_listo_gana", cuenta, 0);
    comprobar("to_listo_fin", gesto_valido, 0);
`else
    dedos = 4'b1111; listo = 1'b0;
    esperar_valido(lat);
    cuenta = 0; cuenta2 = 0;
    repeat (30) begin
      tick();
      cuenta  += int'(error_timeout);
      cuenta2 += int'(!gesto_valido);
    end
    comprobar("sin_to_error", cuenta, 0);
    comprobar("sin_to_espera", cuenta2, 0);
    listo = 1'b1;
    tick();
    comprobar("sin_to_fin", gesto_valido, 0);
`endif
    esperar_libre(n);

    // Random segments of held patterns, listo modes and rare resets
    repeat (300) begin
      int modo;
      case ($urandom_range(0, 5))
        0:       dedos = 4'b0000;
        1:       dedos = 4'b0011;
        2:       dedos = 4'b0111;
        3:       dedos = 4'b1111;
        default: dedos = 4'($urandom_range(0, 15));
      endcase
      modo = int'($urandom_range(0, 2));
      repeat ($urandom_range(1, 12)) begin
        listo = (modo == 0) ? 1'b0 : (modo == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        rst_n = ($urandom_range(0, 150) != 0);
        tick();
      end
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", n_chk, n_ok);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/controlador_gestos.md
# controlador_gestos

Sequencing controller for the finger-sensor front end. It synchronises the four raw finger inputs and maps them to a 2-bit gesture code. A gesture is accepted only after it has held steady for a programmable number of cycles. The accepted gesture goes to the game logic over a valid/ready handshake, and the block then waits for the hand to be released before it re-arms.

## Interface
Parameters:
- `ESTABLE`, default 16: consecutive cycles a code must hold to be accepted; also the release hold time. Legal range ≥ 2.
- `TIMEOUT`, default 1024: maximum cycles `gesto_valido` may wait for `listo`. Used only with `GESTO_TIMEOUT_EN`.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `dedos`  in  4  raw finger sensors, asynchronous to `clk`; bit0 = finger A … bit3 = finger D.
- `listo`  in  1  consumer ready.
- `gesto_valido`  out  1  accepted gesture available.
- `gesto`  out  2  accepted gesture code; meaningful only while `gesto_valido`=1.
- `ocupado`  out  1  high in every state except ESPERA.
- `error_timeout`  out  1  one-cycle pulse when a gesture is dropped for timeout.

## Operation
- Synchroniser: two-flop synchroniser on all 4 bits, giving `dedos_s`.
- Code map (combinational on `dedos_s`):
  - 4'b0011 → 2'b01
  - 4'b0111 → 2'b10
  - 4'b1111 → 2'b11
  - any other value → 2'b00 (no gesture). This gives `codigo`.
- Registers: `candidato` (2 bits) and a stability counter `cnt` of width $clog2(ESTABLE+1).
- States and transitions:
  - **ESPERA**
    - `codigo`≠00 → FILTRO; load `candidato`=`codigo`, `cnt`=1.
  - **FILTRO**
    - `codigo`=00 → ESPERA.
    - `codigo`≠`candidato` but nonzero → stay in FILTRO; reload `candidato`=`codigo`, `cnt`=1.
    - `codigo`=`candidato` and `cnt`=ESTABLE-1 → VALIDO; register `gesto`=`candidato`.
    - `codigo`=`candidato` otherwise → `cnt`++.
  - **VALIDO**
    - `gesto_valido`=1 and `gesto` held constant.
    - `listo`=1 → SOLTAR, with the handshake completing on that edge.
    - Input changes are ignored while in VALIDO.
  - **SOLTAR**
    - `codigo`=00 → `cnt`++.
    - `codigo`≠00 → `cnt`=0.
    - `cnt`=ESTABLE-1 with `codigo`=00 → ESPERA.
    - `cnt` is cleared on entry.
- Exactly one handshake occurs per hand presentation. A held gesture never re-fires.
- Reset (`rst_n`=0 at a rising edge) is valid in any state, including mid-FILTRO or mid-VALIDO:
  - state = ESPERA; synchroniser flops, `candidato`, `cnt` and timeout counter = 0.
  - `gesto_valido`=0, `gesto`=00, `ocupado`=0, `error_timeout`=0.
  - A pending gesture is discarded without a handshake.

## Timing
- All outputs are registered.
- A stable nonzero code applied on `dedos` raises `gesto_valido` on the (ESTABLE+2)-th rising edge, counting the first edge that samples the new value as edge 1.
- `gesto_valido` falls on the edge where `listo`=1 is sampled. If `listo` is already high on entry to VALIDO, `gesto_valido` is high for exactly 1 cycle.
- Consumer may hold `listo` high permanently.
- After release, re-arm to ESPERA happens ESTABLE cycles after `codigo` first reads 00 in SOLTAR.
- A code glitch shorter than ESTABLE cycles never produces `gesto_valido`.

## Configuration
- Macro: `GESTO_TIMEOUT_EN`.
- Defined:
  - A counter runs while in VALIDO.
  - When it reaches TIMEOUT-1 with `listo`=0, the block drops `gesto_valido` and goes to SOLTAR.
  - `error_timeout` pulses high for 1 cycle on that transition edge.
  - A `listo` arriving on that same edge wins: normal handshake, no error.
- Undefined:
  - VALIDO waits indefinitely.
  - `error_timeout` is tied to 0 and no counter is synthesised.

## Structure
- Package `gestos_pkg` holds:
  - `gesto_t` (2-bit enum: NINGUNO, G1, G2, G3).
  - `estado_t` (ESPERA, FILTRO, VALIDO, SOLTAR).
  - the code-map function `mapa_dedos(logic [3:0]) → gesto_t`.
- One sub-module: `sincronizador` (parameterised-width two-flop synchroniser, reset to 0).

## Test plan
All scenarios use ESTABLE=4, TIMEOUT=8, `listo`=1 unless stated.
- Reset:
  - Stimulus: assert `rst_n`=0 for 2 edges with `dedos`=1111.
  - Response: all outputs 0; state ESPERA.
- Basic handshake:
  - Stimulus: `dedos`=0011 held.
  - Response: `gesto_valido`=1 with `gesto`=01 on edge 6, low on edge 7, never high again while held.
- Glitch filtering and candidate restart:
  - Stimulus: `dedos`=0111 for 3 cycles, then 1111 held.
  - Response: no 10 is ever issued; `gesto`=11 is issued 4 cycles after the 1111 code appears.
- Backpressure, release and mid-VALIDO reset:
  - Stimulus: `listo`=0 for 5 cycles of VALIDO, then 1; then `dedos`=0000.
  - Response: `gesto` constant throughout; `ocupado` drops 4 cycles after 0000 reaches `codigo`.
  - Stimulus: `rst_n` pulsed during VALIDO.
  - Response: immediate return to ESPERA with no handshake.
- Timeout (`GESTO_TIMEOUT_EN` defined):
  - Stimulus: `listo`=0 held.
  - Response: `error_timeout` pulses once after 8 VALIDO cycles; block goes to SOLTAR.
  - Stimulus: same build, `listo` rising on the 8th cycle.
  - Response: normal handshake, no error.
